// File: rtl/washer_pkg.sv
// washer_pkg: state encoding, default phase durations and the pass-count clamp
// shared by the washer sequencer and its testbench.
package washer_pkg;
    typedef enum logic [2:0] {IDLE = 3'd0, SOAK, WASH, RINSE, SPIN, PAUSE} state_t;
    localparam int SOAK_CYC_D   = 8;
    localparam int WASH_CYC_D   = 16;
    localparam int RINSE_CYC_D  = 12;
    localparam int SPIN_CYC_D   = 10;
    localparam int PRICE_D      = 2;
    localparam int MAX_REPEAT_D = 3;
    function automatic int clamp_reps(input int n, input int max_rep);
        return (n < 1) ? 1 : ((n > max_rep) ? max_rep : n);
    endfunction
endpackage

// File: rtl/phase_timer.sv
// phase_timer: down-counter for phase durations; load wins over en, and the
// counter holds at zero.
module phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end
    assign zero = (cnt == '0);
endmodule

// File: rtl/wash_cycle_ctrl.sv
// wash_cycle_ctrl: coin-operated washer sequencer (SOAK, WASH/RINSE passes, SPIN).
// Define LID_PAUSE_ALL_EN to let an open lid pause every phase, not only SPIN.
module wash_cycle_ctrl
    import washer_pkg::*;
#(
    parameter int SOAK_CYC   = SOAK_CYC_D,
    parameter int WASH_CYC   = WASH_CYC_D,
    parameter int RINSE_CYC  = RINSE_CYC_D,
    parameter int SPIN_CYC   = SPIN_CYC_D,
    parameter int PRICE      = PRICE_D,
    parameter int MAX_REPEAT = MAX_REPEAT_D,
    parameter int CRD_W      = 4,
    parameter int RPT_W      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             coin,
    input  logic             lid_open,
    input  logic [RPT_W-1:0] n_repeat,
    output logic             soak,
    output logic             wash,
    output logic             rinse,
    output logic             spin,
    output logic             paused,
    output logic             brake,
    output logic             busy,
    output logic [CRD_W-1:0] credit,
    output logic [RPT_W-1:0] pass_idx
);
    localparam int MAX_A   = (SOAK_CYC > WASH_CYC) ? SOAK_CYC : WASH_CYC;
    localparam int MAX_B   = (RINSE_CYC > SPIN_CYC) ? RINSE_CYC : SPIN_CYC;
    localparam int MAX_DUR = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW      = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;
    localparam int CW1     = CRD_W + 1;

    state_t           state, next;
    state_t           resume;
    logic [RPT_W-1:0] reps;
    logic [TW-1:0]    load_val;
    logic [CW1-1:0]   sum;
    logic             load, zero, phase, can_pause, start;

    assign phase = (state == SOAK) || (state == WASH) || (state == RINSE) || (state == SPIN);
    assign start = (state == IDLE) && (credit >= CRD_W'(PRICE)) && !lid_open;

`ifdef LID_PAUSE_ALL_EN
    state_t ret;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ret <= IDLE;
        else if (state != PAUSE && next == PAUSE)
            ret <= state;
    end
    assign can_pause = phase;
    assign resume    = ret;
    assign brake     = (state == PAUSE) && (ret == SPIN);
`else
    assign can_pause = (state == SPIN);
    assign resume    = SPIN;
    assign brake     = (state == PAUSE);
`endif

    // The timer keeps counting on the edge that enters PAUSE, so that cycle counts as active.
    phase_timer #(.W(TW)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .load_val(load_val),
        .en      (phase),
        .zero    (zero)
    );

    always_comb begin
        next     = state;
        load     = 1'b0;
        load_val = '0;
        case (state)
            IDLE: if (start) begin
                next     = SOAK;
                load     = 1'b1;
                load_val = TW'(SOAK_CYC - 1);
            end
            SOAK: if (zero) begin
                next     = WASH;
                load     = 1'b1;
                load_val = TW'(WASH_CYC - 1);
            end else if (can_pause && lid_open) next = PAUSE;
            WASH: if (zero) begin
                next     = RINSE;
                load     = 1'b1;
                load_val = TW'(RINSE_CYC - 1);
            end else if (can_pause && lid_open) next = PAUSE;
            RINSE: if (zero) begin
                next     = (pass_idx < reps) ? WASH : SPIN;
                load     = 1'b1;
                load_val = (pass_idx < reps) ? TW'(WASH_CYC - 1) : TW'(SPIN_CYC - 1);
            end else if (can_pause && lid_open) next = PAUSE;
            SPIN: if (zero) next = IDLE;
            else if (lid_open) next = PAUSE;
            PAUSE: if (!lid_open) next = resume;
            default: next = IDLE;
        endcase
    end

    assign sum = {1'b0, credit} + CW1'(coin) - (start ? CW1'(PRICE) : CW1'(0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            credit   <= '0;
            pass_idx <= '0;
            reps     <= '0;
        end else begin
            state  <= next;
            credit <= sum[CRD_W] ? {CRD_W{1'b1}} : sum[CRD_W-1:0];
            if (start) begin
                pass_idx <= RPT_W'(1);
                reps     <= RPT_W'(clamp_reps(int'(n_repeat), MAX_REPEAT));
            end else if (state == RINSE && zero && pass_idx < reps)
                pass_idx <= pass_idx + 1'b1;
            else if (state == SPIN && zero)
                pass_idx <= '0;
        end
    end

    assign soak   = (state == SOAK);
    assign wash   = (state == WASH);
    assign rinse  = (state == RINSE);
    assign spin   = (state == SPIN);
    assign paused = (state == PAUSE);
    assign busy   = (state != IDLE);
endmodule
